// File: rtl/i2c_slave_pkg.sv
// rtl/i2c_slave_pkg.sv - FSM encoding, I2C bit constants and default address for i2c_slave_regs
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } state_t;

  // SDA level left behind by a START / STOP edge while SCL is high
  localparam logic SDA_START_LVL = 1'b0;
  localparam logic SDA_STOP_LVL  = 1'b1;
  localparam logic ACK_BIT       = 1'b0;
  localparam logic NACK_BIT      = 1'b1;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h72;

endpackage

// File: rtl/i2c_deb_edge.sv
// rtl/i2c_deb_edge.sv - pin debouncer with level, rise and fall strobes
module i2c_deb_edge #(
  parameter int DEB_LEN = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [DEB_LEN-1:0] pipe;
  logic               deb;
  logic [2:0]         hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '1;
      deb  <= 1'b1;
      hist <= '1;
    end else begin
      pipe <= {pipe[DEB_LEN-2:0], din};
      if (&pipe[DEB_LEN-1:1])
        deb <= 1'b1;
      else if (~|pipe[DEB_LEN-1:1])
        deb <= 1'b0;
      hist <= {hist[1:0], deb};
    end
  end

  // level is taken from the same history stage as the strobes so they stay aligned
  assign level = hist[1];
  assign rise  = hist[1] & ~hist[2];
  assign fall  = ~hist[1] & hist[2];

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C slave register bank with pointer and bursts; I2C_SLAVE_REGS_AUTOINC_EN enables pointer auto-increment
module i2c_slave_regs
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         NREGS      = 8,
  parameter int         DEB_LEN    = 10,
  localparam int        PW         = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SCL,
  inout  wire                SDA,
  output logic [8*NREGS-1:0] regs_q,
  output logic               wr_stb,
  output logic [PW-1:0]      wr_idx,
  output logic               busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_deb_edge #(.DEB_LEN(DEB_LEN)) u_scl (
    .clk(clk), .rst_n(rst), .din(SCL),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_deb_edge #(.DEB_LEN(DEB_LEN)) u_sda (
    .clk(clk), .rst_n(rst), .din(SDA),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = scl_lvl & (sda_rise | sda_fall) & (sda_lvl == SDA_START_LVL);
  assign stop_det  = scl_lvl & (sda_rise | sda_fall) & (sda_lvl == SDA_STOP_LVL);

  state_t        state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          rw;
  logic          sda_oe;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [7:0]    regs [NREGS];
  logic [7:0]    rx_byte;

  assign rx_byte = {shreg[6:0], sda_lvl};

`ifdef I2C_SLAVE_REGS_AUTOINC_EN
  assign ptr_nxt = ptr + PW'(1);
`else
  assign ptr_nxt = ptr;
`endif

  assign SDA = sda_oe ? 1'b0 : 1'bz;

  always_comb begin
    regs_q = '0;
    for (int i = 0; i < NREGS; i++)
      regs_q[8*i +: 8] = regs[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      ptr     <= '0;
      wr_stb  <= 1'b0;
      wr_idx  <= '0;
      busy    <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (stop_det || start_det) begin
        state   <= stop_det ? ST_IDLE : ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    state <= ST_ADDR_ACK;
                    rw    <= rx_byte[0];
                    busy  <= 1'b1;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else if (state == ST_PTR) begin
                  ptr   <= rx_byte[PW-1:0];
                  state <= ST_PTR_ACK;
                end else begin
                  regs[ptr] <= rx_byte;
                  wr_stb    <= 1'b1;
                  wr_idx    <= ptr;
                  ptr       <= ptr_nxt;
                  state     <= ST_WDATA_ACK;
                end
              end
            end
          end
          // first SCL fall after bit 8 asserts the ACK, the next one releases it
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (state == ST_ADDR_ACK && rw) begin
                state  <= ST_RDATA;
                shreg  <= {regs[ptr][6:0], 1'b0};
                sda_oe <= ~regs[ptr][7];
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                ptr     <= ptr_nxt;
                state   <= ST_RDATA_ACK;
              end else begin
                sda_oe <= ~shreg[7];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == NACK_BIT)
                state <= ST_IGNORE;
            end else if (scl_fall) begin
              state  <= ST_RDATA;
              shreg  <= {regs[ptr][6:0], 1'b0};
              sda_oe <= ~regs[ptr][7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - scoreboard bench for i2c_slave_regs driven by a bit-banged I2C master
module tb_i2c_slave_regs;

  localparam int         NREGS   = 8;
  localparam int         DEB_LEN = 10;
  localparam int         Q       = 16;
  localparam logic [6:0] ADDR    = 7'h72;
  localparam logic [7:0] AW      = {ADDR, 1'b0};
  localparam logic [7:0] AR      = {ADDR, 1'b1};

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic scl   = 1'b1;
  logic sda_m = 1'b1;
  wire  sda_w;

  logic [8*NREGS-1:0] regs_q;
  logic               wr_stb;
  logic [2:0]         wr_idx;
  logic               busy;

  pullup (sda_w);
  assign sda_w = sda_m ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_slave_regs #(.SLAVE_ADDR(ADDR), .NREGS(NREGS), .DEB_LEN(DEB_LEN)) dut (
    .clk(clk), .rst(rst), .SCL(scl), .SDA(sda_w),
    .regs_q(regs_q), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
  );

  typedef struct { string name; int val; } item_t;
  typedef struct { int idx; int data; } wr_t;

  item_t exp_q[$];
  item_t obs_q[$];
  wr_t   exp_wr[$];
  item_t mo, me;
  wr_t   mw;

  int   nvec = 0;
  int   nfail = 0;
  int   drv_cnt = 0;
  int   busy_cnt = 0;
  logic watch = 1'b0;

  logic [7:0] mreg [NREGS];
  int         mptr;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_stb) begin
      if (exp_wr.size() == 0) begin
        check("spurious_wr_stb", {63'd0, wr_stb}, 64'd0);
      end else begin
        mw = exp_wr.pop_front();
        check("wr_idx", {61'd0, wr_idx}, 64'(mw.idx));
        check("wr_data", {56'd0, regs_q[8*mw.idx +: 8]}, 64'(mw.data));
      end
    end
    while (obs_q.size() > 0) begin
      mo = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL %s: observed %0h with no expected entry", mo.name, mo.val);
      end else begin
        me = exp_q.pop_front();
        check(me.name, 64'(mo.val), 64'(me.val));
      end
    end
    if (watch && sda_m && !sda_w) drv_cnt++;
    if (watch && busy) busy_cnt++;
  end

  function automatic void adv_ptr();
`ifdef I2C_SLAVE_REGS_AUTOINC_EN
    mptr = (mptr + 1) % NREGS;
`endif
  endfunction

  function automatic logic [8*NREGS-1:0] mpack();
    logic [8*NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[8*i +: 8] = mreg[i];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_x(input logic b, output logic r);
    tick(Q); sda_m = b;
    tick(Q); scl = 1'b1;
    tick(Q); r = sda_w;
    tick(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    tick(Q); sda_m = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); sda_m = 1'b0;
    tick(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); sda_m = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); sda_m = 1'b1;
    tick(2*Q);
  endtask

  task automatic wb(input logic [7:0] d, input logic exp_ack);
    logic r;
    exp_q.push_back('{name: $sformatf("ack_%02h", d), val: int'(exp_ack)});
    for (int i = 7; i >= 0; i--) bit_x(d[i], r);
    bit_x(1'b1, r);
    obs_q.push_back('{name: "ack", val: int'(r)});
  endtask

  task automatic wr(input logic [7:0] d);
    exp_wr.push_back('{idx: mptr, data: int'(d)});
    mreg[mptr] = d;
    adv_ptr();
    wb(d, 1'b0);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    wb(p, 1'b0);
    mptr = int'(p) % NREGS;
  endtask

  task automatic rb(input logic mack);
    logic [7:0] d;
    logic       r;
    exp_q.push_back('{name: $sformatf("rdata_r%0d", mptr), val: int'(mreg[mptr])});
    adv_ptr();
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(mack, r);
    obs_q.push_back('{name: "rdata", val: int'(d)});
  endtask

  initial begin
    logic r;
    for (int i = 0; i < NREGS; i++) mreg[i] = 8'h00;
    mptr = 0;

    tick(5);
    check("rst_regs", regs_q, 64'd0);
    check("rst_wr_stb", {63'd0, wr_stb}, 64'd0);
    check("rst_wr_idx", {61'd0, wr_idx}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_sda", {63'd0, sda_w}, 64'd1);
    rst = 1'b1;
    tick(20);

    // single write to register 3
    i2c_start();
    wb(AW, 1'b0);
    check("busy_after_match", {63'd0, busy}, 64'd1);
    set_ptr(8'h03);
    wr(8'hA5);
    i2c_stop();
    check("t1_reg3", {56'd0, regs_q[31:24]}, 64'h A5);
    check("t1_busy_after_stop", {63'd0, busy}, 64'd0);

    // two-byte burst starting at the last register
    i2c_start();
    wb(AW, 1'b0);
    set_ptr(8'h07);
    wr(8'h11);
    wr(8'h22);
    i2c_stop();
    check("t2_reg7", {56'd0, regs_q[63:56]}, {56'd0, mreg[7]});
    check("t2_reg0", {56'd0, regs_q[7:0]}, {56'd0, mreg[0]});

    // seed regs 1..2, then pointer write + repeated START + read ACK/NACK
    i2c_start();
    wb(AW, 1'b0);
    set_ptr(8'h01);
    wr(8'h5A);
    wr(8'hC3);
    i2c_stop();
    i2c_start();
    wb(AW, 1'b0);
    set_ptr(8'h01);
    i2c_start();
    wb(AR, 1'b0);
    rb(1'b0);
    rb(1'b1);
    check("t3_busy_before_stop", {63'd0, busy}, 64'd1);
    check("t3_sda_released", {63'd0, sda_w}, 64'd1);
    i2c_stop();
    check("t3_busy_after_stop", {63'd0, busy}, 64'd0);

    // foreign address: slave must stay silent and idle
    drv_cnt  = 0;
    busy_cnt = 0;
    watch    = 1'b1;
    i2c_start();
    wb({7'h50, 1'b0}, 1'b1);
    wb(8'h12, 1'b1);
    wb(8'h34, 1'b1);
    i2c_stop();
    watch = 1'b0;
    check("t4_sda_driven_cycles", 64'(drv_cnt), 64'd0);
    check("t4_busy_cycles", 64'(busy_cnt), 64'd0);

    // partial data byte cut by STOP causes no write
    i2c_start();
    wb(AW, 1'b0);
    set_ptr(8'h04);
    wr(8'h9C);
    i2c_stop();
    i2c_start();
    wb(AW, 1'b0);
    set_ptr(8'h04);
    for (int i = 0; i < 4; i++) bit_x(1'b1, r);
    i2c_stop();
    check("t5_busy_idle", {63'd0, busy}, 64'd0);
    i2c_start();
    wb(AR, 1'b0);
    rb(1'b1);
    i2c_stop();
    check("t5_regs", regs_q, mpack());

    // reset while the slave is driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_x(AW[i], r);
    tick(Q); sda_m = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q);
    check("t6_ack_driven", {63'd0, sda_w}, 64'd0);
    rst = 1'b0;
    #1;
    check("t6_sda_released_in_rst", {63'd0, sda_w}, 64'd1);
    tick(Q); scl = 1'b0;
    tick(Q); scl = 1'b1;
    tick(2*Q);
    rst = 1'b1;
    tick(20);
    for (int i = 0; i < NREGS; i++) mreg[i] = 8'h00;
    mptr = 0;
    check("t6_regs_cleared", regs_q, 64'd0);
    check("t6_busy", {63'd0, busy}, 64'd0);
    i2c_start();
    wb(AR, 1'b0);
    rb(1'b0);
    rb(1'b0);
    rb(1'b1);
    i2c_stop();

    // three-byte burst to register 2
    i2c_start();
    wb(AW, 1'b0);
    set_ptr(8'h02);
    wr(8'h10);
    wr(8'h20);
    wr(8'h30);
    i2c_stop();
    check("t7_reg2", {56'd0, regs_q[23:16]}, {56'd0, mreg[2]});

    tick(10);
    check("final_regs", regs_q, mpack());
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("exp_wr_drained", 64'(exp_wr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
